// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl: prescaler plus burst FSM that generates one-cycle enable
//   strobes for the downstream 8-bit counter, every (div_q+1) clocks while running.
// Ports: clk/reset (async, active-high); start/stop requests; divisor/burst_len
//   (latched at start); enable strobe, busy (RUN state), done (one-cycle pulse).
// Option: define COUNT_ENABLE_CTRL_SYNC_EN to pass start/stop through 2-flop
//   synchronisers (adds 2 cycles from pin to effect); otherwise used directly.
module count_enable_ctrl #(
   parameter int PRESCALE_W = 8,
   parameter int BURST_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [PRESCALE_W-1:0] divisor,
   input  logic [BURST_W-1:0]    burst_len,
   output logic                  enable,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);
   localparam logic [BURST_W-1:0]    BURST_ONE = BURST_W'(1);

   logic start_s;
   logic stop_s;

`ifdef COUNT_ENABLE_CTRL_SYNC_EN
   logic [1:0] start_sync_q, start_sync_d;
   logic [1:0] stop_sync_q,  stop_sync_d;

   always_comb begin
      start_sync_d = {start_sync_q[0], start};
      stop_sync_d  = {stop_sync_q[0], stop};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_sync_q <= '0;
         stop_sync_q  <= '0;
      end else begin
         start_sync_q <= start_sync_d;
         stop_sync_q  <= stop_sync_d;
      end
   end

   assign start_s = start_sync_q[1];
   assign stop_s  = stop_sync_q[1];
`else
   assign start_s = start;
   assign stop_s  = stop;
`endif

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [BURST_W-1:0]    cnt_q,   cnt_d;
   logic [PRESCALE_W-1:0] div_q,   div_d;
   logic [BURST_W-1:0]    burst_q, burst_d;

   // Outputs depend only on flops (plus stop for the gate), so an async reset
   // drops them immediately without a clock.
   assign enable = (state_q == RUN) && (presc_q == div_q) && !stop_s;
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            // stop has priority over a simultaneous start
            if (start_s && !stop_s) begin
               div_d   = divisor;
               burst_d = burst_len;
               presc_d = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop_s) begin
               presc_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               presc_d = (presc_q == div_q) ? '0 : presc_q + PRESC_ONE;
               // burst_q == 0 means continuous: strobe count stays frozen
               if (enable && (burst_q != '0)) begin
                  if (cnt_q == burst_q - BURST_ONE) begin
                     cnt_d   = '0;
                     state_d = DONE;
                  end else begin
                     cnt_d = cnt_q + BURST_ONE;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         burst_q <= burst_d;
      end
   end

endmodule
